servo_frame_sched: RTL

- Multi-channel servo scheduler. Owns one shared 50 Hz frame counter and N_CH PWM outputs.
- Accepts angle/sweep commands over a valid/ready handshake.
- Slews each channel's current angle toward its target once per frame, at a bounded rate.
- Converts each angle to a pulse width for the next frame.
- Sits between the host/control logic and the servo pins; replaces per-servo free-running PWM blocks.

---
 rtl/servo_pkg.sv | 33 +++
 rtl/servo_slew_step.sv | 60 ++++++
 rtl/servo_frame_sched.sv | 99 +++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared constants, per-channel state record and angle-to-pulse helper
// for the servo frame scheduler.
package servo_pkg;

    localparam int CNT_W       = 20;
    localparam int ANG_W       = 8;
    localparam int PERIOD_DEF  = 960000;
    localparam int MIN_PW_DEF  = 24000;
    localparam int DEG_CYC_DEF = 534;
    localparam int MAX_DEG_DEF = 180;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef struct packed {
        logic [ANG_W-1:0] cur;
        logic [ANG_W-1:0] target;
        logic             sweep;
        dir_e             dir;
        logic [CNT_W-1:0] pw;
    } chan_state_t;

    function automatic logic [CNT_W-1:0] angle_to_pw(
        input logic [ANG_W-1:0] ang,
        input int               min_pw,
        input int               deg_cyc
    );
        return CNT_W'(min_pw) + CNT_W'(ang) * CNT_W'(deg_cyc);
    endfunction

endpackage

// File: rtl/servo_slew_step.sv
// Next-angle / next-direction for one channel, applied at each frame
// boundary: either a 0..MAX_DEG bounce or a bounded seek toward target.
module servo_slew_step
    import servo_pkg::*;
#(
    parameter int STEP    = 1,
    parameter int MAX_DEG = MAX_DEG_DEF
) (
    input  logic [ANG_W-1:0] cur,
    input  logic [ANG_W-1:0] target,
    input  logic             sweep,
    input  dir_e             dir,
    output logic [ANG_W-1:0] cur_next,
    output dir_e             dir_next
);

    // One spare bit so cur+STEP cannot wrap before the ceiling compare.
    localparam int             AW1    = ANG_W + 1;
    localparam logic [AW1-1:0] STEP_W = AW1'(STEP);
    localparam logic [AW1-1:0] MAX_W  = AW1'(MAX_DEG);

    logic [AW1-1:0] cur_w;
    logic [AW1-1:0] tgt_w;
    logic [AW1-1:0] up_sum;
    logic [AW1-1:0] diff;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        cur_w    = {1'b0, cur};
        tgt_w    = {1'b0, target};
        up_sum   = cur_w + STEP_W;
        diff     = (tgt_w >= cur_w) ? (tgt_w - cur_w) : (cur_w - tgt_w);
        cur_next = cur;
        dir_next = dir;

        if (sweep) begin
            if (dir == DIR_UP) begin
                if (up_sum >= MAX_W) begin
                    cur_next = MAX_W[ANG_W-1:0];
                    dir_next = DIR_DOWN;
                end else begin
                    cur_next = up_sum[ANG_W-1:0];
                end
            end else begin
                if (cur_w <= STEP_W) begin
                    cur_next = '0;
                    dir_next = DIR_UP;
                end else begin
                    cur_next = ANG_W'(cur_w - STEP_W);
                end
            end
        end else if (diff > STEP_W) begin
            cur_next = (tgt_w > cur_w) ? ANG_W'(cur_w + STEP_W) : ANG_W'(cur_w - STEP_W);
        end else begin
            // Within one step of target: land exactly on it, never overshoot.
            cur_next = target;
        end
    end

endmodule

// File: rtl/servo_frame_sched.sv
// Multi-channel servo scheduler: one shared frame counter, a command port,
// per-frame slew of each channel and registered PWM generation.
module servo_frame_sched
    import servo_pkg::*;
#(
    parameter int  N_CH    = 4,
    parameter int  PERIOD  = PERIOD_DEF,
    parameter int  MIN_PW  = MIN_PW_DEF,
    parameter int  DEG_CYC = DEG_CYC_DEF,
    parameter int  STEP    = 1,
    parameter int  MAX_DEG = MAX_DEG_DEF,
    localparam int CW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CW-1:0]    cmd_chan,
    input  logic [ANG_W-1:0] cmd_angle,
    input  logic             cmd_sweep,
    output logic             frame_tick,
    output logic [N_CH-1:0]  busy,
    output logic [N_CH-1:0]  pwm_out
);

    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);
    localparam logic [ANG_W-1:0] MAX_A = ANG_W'(MAX_DEG);

    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] counter_next;
    logic             boundary;
    logic             accept;
    logic [ANG_W-1:0] angle_clamped;

    assign boundary      = (counter == LAST);
    assign counter_next  = boundary ? '0 : counter + 1'b1;
    // Commands are refused on the boundary so they never race the slew update.
    assign cmd_ready     = rst_n && !boundary;
    assign accept        = cmd_valid && cmd_ready;
    assign angle_clamped = (cmd_angle > MAX_A) ? MAX_A : cmd_angle;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            counter    <= '0;
            frame_tick <= 1'b0;
        end else begin
            counter    <= counter_next;
            frame_tick <= (counter_next == LAST);
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        chan_state_t      st_q;
        logic             pwm_q;
        logic             hit;
        logic [ANG_W-1:0] cur_nx;
        dir_e             dir_nx;

        // Out-of-range channel numbers match no slot and are silently dropped.
        assign hit = accept && (int'(cmd_chan) == ch);

        servo_slew_step #(
            .STEP    (STEP),
            .MAX_DEG (MAX_DEG)
        ) u_step (
            .cur      (st_q.cur),
            .target   (st_q.target),
            .sweep    (st_q.sweep),
            .dir      (st_q.dir),
            .cur_next (cur_nx),
            .dir_next (dir_nx)
        );

        always_ff @(posedge clk) begin
            // NOTE: per-channel state is a handful of flops, not a RAM, so it is fully reset.
            if (!rst_n) begin
                st_q  <= '{cur: '0, target: '0, sweep: 1'b0, dir: DIR_UP, pw: CNT_W'(MIN_PW)};
                pwm_q <= 1'b0;
            end else begin
                if (hit) begin
                    st_q.target <= angle_clamped;
                    st_q.sweep  <= cmd_sweep;
                end
                // pw changes only on the boundary, so a pulse is never cut mid-frame.
                if (boundary) begin
                    st_q.cur <= cur_nx;
                    st_q.dir <= dir_nx;
                    st_q.pw  <= angle_to_pw(cur_nx, MIN_PW, DEG_CYC);
                end
                pwm_q <= (counter < st_q.pw);
            end
        end

        assign busy[ch]    = st_q.sweep || (st_q.cur != st_q.target);
        assign pwm_out[ch] = pwm_q;
    end

endmodule
